tape_pulse_gen: RTL and testbench

- Tape-signal generator for the SAVE / tape-output path. It is the transmit counterpart of sync_detector.
- Converts a stream of block bytes into a ZX Spectrum-format square wave on aud: pilot tone, sync1, sync2, MSB-first data bits, then an inter-block pause.
- Bytes come from an upstream buffer or FIFO through a valid/ready handshake.
- Durations are specified in Z80 T-states and scaled to clk cycles at elaboration.

---
 rtl/tape_pulse_gen_if.sv | 24 ++
 rtl/tape_pulse_gen.sv | 235 +++++++++++++++++++++++
 tb/tb_tape_pulse_gen.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tape_pulse_gen_if.sv
// Byte stream feeding the tape pulse generator: a valid/ready handshake
// carrying one block byte and an end-of-block marker.
interface tape_pulse_gen_if;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_last;
  logic       byte_ready;

  // Upstream buffer / FIFO side
  modport master (
    output byte_data,
    output byte_valid,
    output byte_last,
    input  byte_ready
  );

  // Pulse generator side
  modport slave (
    input  byte_data,
    input  byte_valid,
    input  byte_last,
    output byte_ready
  );
endinterface

// File: rtl/tape_pulse_gen.sv
// ZX Spectrum tape signal generator (SAVE path). Turns a block of bytes into
// a square wave on aud: pilot tone, sync1, sync2, MSB-first data bits, then
// a silent inter-block pause. All durations are given in Z80 T-states and
// converted to clk cycles at elaboration with integer truncation.
module tape_pulse_gen #(
  parameter int unsigned CLK_FREQ    = 27000000,
  parameter int unsigned TSTATE_FREQ = 3500000,
  parameter int unsigned PILOT_HDR   = 8063,
  parameter int unsigned PILOT_DATA  = 3223,
  parameter int unsigned PAUSE_MS    = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             header,
  tape_pulse_gen_if.slave  byte_if,
  output logic             aud,
  output logic             busy,
  output logic             done,
  output logic             underrun
);

  // T-states to clk cycles; 64-bit intermediate because T*CLK_FREQ
  // overflows 32 bits at the default clock.
  function automatic logic [31:0] t_to_cyc(input logic [63:0] t);
    logic [63:0] c;
    c = (t * 64'(CLK_FREQ)) / 64'(TSTATE_FREQ);
    return c[31:0];
  endfunction

  localparam logic [31:0] PILOT_LEN = t_to_cyc(64'd2168);
  localparam logic [31:0] SYNC1_LEN = t_to_cyc(64'd667);
  localparam logic [31:0] SYNC2_LEN = t_to_cyc(64'd735);
  localparam logic [31:0] BIT0_LEN  = t_to_cyc(64'd855);
  localparam logic [31:0] BIT1_LEN  = t_to_cyc(64'd1710);

  localparam logic [63:0] PAUSE_RAW = 64'(PAUSE_MS) * (64'(CLK_FREQ) / 64'd1000);
  localparam logic [31:0] PAUSE_LEN = (PAUSE_RAW == 64'd0) ? 32'd1 : PAUSE_RAW[31:0];

  // Pilot counter holds "pulses still to go after the current one".
  localparam logic [15:0] PILOT_HDR_M1  = 16'(PILOT_HDR - 1);
  localparam logic [15:0] PILOT_DATA_M1 = 16'(PILOT_DATA - 1);

  typedef enum logic [2:0] {
    IDLE,
    PILOT,
    SYNC1,
    SYNC2,
    LOAD,
    DATA,
    PAUSE
  } state_e;

  // Reload value of the level counter for one half of a data bit.
  function automatic logic [31:0] bit_len_m1(input logic b);
    return b ? (BIT1_LEN - 32'd1) : (BIT0_LEN - 32'd1);
  endfunction

  state_e      state_q,    state_d;
  logic [31:0] cnt_q,      cnt_d;       // cycles left in the current level, minus one
  logic [15:0] pulses_q,   pulses_d;    // pilot pulses remaining after this one
  logic [7:0]  shreg_q,    shreg_d;     // bit being sent is always shreg_q[7]
  logic [2:0]  bit_idx_q,  bit_idx_d;
  logic        last_q,     last_d;
  logic        half_q,     half_d;      // 1 while sending the second half of a bit
  logic        first_q,    first_d;     // LOAD reached straight from SYNC2
  logic        aud_q,      aud_d;
  logic        busy_q,     busy_d;
  logic        ready_q,    ready_d;
  logic        done_q,     done_d;
  logic        underrun_q, underrun_d;

  // Next-state and next-output logic for the whole block sequence.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave
    // it unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    pulses_d   = pulses_q;
    shreg_d    = shreg_q;
    bit_idx_d  = bit_idx_q;
    last_d     = last_q;
    half_d     = half_q;
    first_d    = first_q;
    aud_d      = aud_q;
    underrun_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = PILOT;
          aud_d    = ~aud_q;
          cnt_d    = PILOT_LEN - 32'd1;
          pulses_d = header ? PILOT_HDR_M1 : PILOT_DATA_M1;
        end
      end

      PILOT: begin
        if (cnt_q != 32'd0) begin
          cnt_d = cnt_q - 32'd1;
        end else begin
          aud_d = ~aud_q;
          if (pulses_q != 16'd0) begin
            pulses_d = pulses_q - 16'd1;
            cnt_d    = PILOT_LEN - 32'd1;
          end else begin
            state_d = SYNC1;
            cnt_d   = SYNC1_LEN - 32'd1;
          end
        end
      end

      SYNC1: begin
        if (cnt_q != 32'd0) begin
          cnt_d = cnt_q - 32'd1;
        end else begin
          aud_d   = ~aud_q;
          state_d = SYNC2;
          cnt_d   = SYNC2_LEN - 32'd1;
        end
      end

      // The edge closing SYNC2 already opens the first data level, so the
      // LOAD cycle lengthens that first level rather than sync2.
      SYNC2: begin
        if (cnt_q != 32'd0) begin
          cnt_d = cnt_q - 32'd1;
        end else begin
          aud_d   = ~aud_q;
          state_d = LOAD;
          first_d = 1'b1;
        end
      end

      LOAD: begin
        first_d = 1'b0;
        if (byte_if.byte_valid) begin
          shreg_d   = byte_if.byte_data;
          last_d    = byte_if.byte_last;
          bit_idx_d = 3'd7;
          half_d    = 1'b0;
          state_d   = DATA;
          cnt_d     = bit_len_m1(byte_if.byte_data[7]);
          if (!first_q) aud_d = ~aud_q;
        end else begin
          underrun_d = 1'b1;
          state_d    = PAUSE;
          aud_d      = 1'b0;
          cnt_d      = PAUSE_LEN - 32'd1;
        end
      end

      DATA: begin
        if (cnt_q != 32'd0) begin
          cnt_d = cnt_q - 32'd1;
        end else if (!half_q) begin
          half_d = 1'b1;
          aud_d  = ~aud_q;
          cnt_d  = bit_len_m1(shreg_q[7]);
        end else if (bit_idx_q != 3'd0) begin
          half_d    = 1'b0;
          aud_d     = ~aud_q;
          bit_idx_d = bit_idx_q - 3'd1;
          shreg_d   = {shreg_q[6:0], 1'b0};
          cnt_d     = bit_len_m1(shreg_q[6]);
        end else if (last_q) begin
          state_d = PAUSE;
          aud_d   = 1'b0;
          cnt_d   = PAUSE_LEN - 32'd1;
        end else begin
          // Previous level simply continues through the LOAD cycle.
          state_d = LOAD;
        end
      end

      // done is shown in the last pause cycle; the exit waits for it so that
      // a one-cycle pause after an underrun still gets a separate done pulse.
      PAUSE: begin
        if (cnt_q != 32'd0) begin
          cnt_d = cnt_q - 32'd1;
        end else if (done_q) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    done_d  = (state_d == PAUSE) && (cnt_d == 32'd0) && !underrun_d;
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == LOAD);
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pulses_q   <= '0;
      shreg_q    <= '0;
      bit_idx_q  <= '0;
      last_q     <= 1'b0;
      half_q     <= 1'b0;
      first_q    <= 1'b0;
      aud_q      <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pulses_q   <= pulses_d;
      shreg_q    <= shreg_d;
      bit_idx_q  <= bit_idx_d;
      last_q     <= last_d;
      half_q     <= half_d;
      first_q    <= first_d;
      aud_q      <= aud_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
    end
  end

  assign aud                = aud_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign underrun           = underrun_q;
  assign byte_if.byte_ready = ready_q;

endmodule

// File: tb/tb_tape_pulse_gen.sv
// Bench for tape_pulse_gen with a scaled-down clock so whole blocks fit in a
// short run. Level lengths at CLK_FREQ=35000 (truncated):
//   pilot 2168T -> 21, sync1 667T -> 6, sync2 735T -> 7,
//   bit0 855T -> 8, bit1 1710T -> 17, pause 1 ms -> 35 cycles.
// Pilot counts are reduced to 5 (header) and 3 (data).
module tb_tape_pulse_gen;

  localparam int PIL     = 21;
  localparam int S1      = 6;
  localparam int S2      = 7;
  localparam int B0      = 8;
  localparam int B1      = 17;
  localparam int PAUSE   = 35;
  localparam int NP_HDR  = 5;
  localparam int NP_DATA = 3;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic start  = 1'b0;
  logic header = 1'b0;
  logic aud, busy, done, underrun;

  tape_pulse_gen_if bif ();

  tape_pulse_gen #(
    .CLK_FREQ   (35000),
    .TSTATE_FREQ(3500000),
    .PILOT_HDR  (NP_HDR),
    .PILOT_DATA (NP_DATA),
    .PAUSE_MS   (1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .header  (header),
    .byte_if (bif),
    .aud     (aud),
    .busy    (busy),
    .done    (done),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- checking
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------ byte source
  logic [8:0] byte_q[$];   // {last, data}

  // Presents the queue head; pops it after an accepted transfer.
  initial begin
    bit xfer;
    bif.byte_valid = 1'b0;
    bif.byte_data  = 8'h00;
    bif.byte_last  = 1'b0;
    forever begin
      @(posedge clk);
      xfer = bif.byte_valid && bif.byte_ready;
      @(negedge clk);
      if (xfer && byte_q.size() > 0) void'(byte_q.pop_front());
      if (byte_q.size() > 0) begin
        bif.byte_valid = 1'b1;
        bif.byte_data  = byte_q[0][7:0];
        bif.byte_last  = byte_q[0][8];
      end else begin
        bif.byte_valid = 1'b0;
        bif.byte_data  = 8'h00;
        bif.byte_last  = 1'b0;
      end
    end
  end

  // ------------------------------------------------------------------ model
  // Expected waveform as a list of cycles, index 0 = first cycle after start
  // is sampled. Built from the level durations: every level alternates,
  // the first data level and each non-final byte's last level are one cycle
  // longer (they contain the LOAD cycle), then PAUSE cycles of silence.
  typedef struct packed {
    logic aud;
    logic ready;
    logic done;
    logic under;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] stim_data[$];
  logic       stim_last[$];
  logic       lvl;

  function automatic void emit(input int dur);
    for (int k = 0; k < dur; k++) exp_q.push_back('{aud: lvl, ready: 1'b0, done: 1'b0, under: 1'b0});
    lvl = ~lvl;
  endfunction

  function automatic void build_model(input bit hdr);
    int s;
    int dur;
    bit under_pend;
    bit ended;
    bit first_lvl;
    bit stretch;
    exp_q.delete();
    lvl        = 1'b1;
    under_pend = 1'b0;
    ended      = 1'b0;
    for (int p = 0; p < (hdr ? NP_HDR : NP_DATA); p++) emit(PIL);
    emit(S1);
    emit(S2);
    if (stim_data.size() == 0) begin
      s = exp_q.size();
      emit(1);
      exp_q[s].ready = 1'b1;
      under_pend     = 1'b1;
    end
    for (int b = 0; b < stim_data.size() && !ended; b++) begin
      for (int k = 7; k >= 0; k--) begin
        for (int h = 0; h < 2; h++) begin
          dur       = stim_data[b][k] ? B1 : B0;
          first_lvl = (b == 0) && (k == 7) && (h == 0);
          stretch   = (k == 0) && (h == 1) && !stim_last[b];
          if (first_lvl) dur++;
          if (stretch) dur++;
          s = exp_q.size();
          emit(dur);
          if (first_lvl) exp_q[s].ready = 1'b1;
          if (stretch) exp_q[exp_q.size()-1].ready = 1'b1;
        end
      end
      if (stim_last[b]) ended = 1'b1;
      else if (b == stim_data.size() - 1) begin
        under_pend = 1'b1;
        ended      = 1'b1;
      end
    end
    for (int i = 0; i < PAUSE; i++)
      exp_q.push_back('{aud: 1'b0, ready: 1'b0, done: (i == PAUSE - 1), under: (under_pend && i == 0)});
  endfunction

  // ------------------------------------------------------ block runner
  int first_ready, done_at, under_at, n_ready, n_done;

  // Starts one block and compares every output on every cycle until a few
  // idle cycles after it ends. spur_a/spur_b: cycles at which start is
  // pulsed again (with header flipped). abort_at: cycle at which reset is
  // asserted; the block then ends with a reset-value check.
  task automatic run_block(input string tag, input bit hdr, input int spur_a,
                           input int spur_b, input int abort_at);
    build_model(hdr);
    byte_q.delete();
    for (int i = 0; i < stim_data.size(); i++) byte_q.push_back({stim_last[i], stim_data[i]});
    @(negedge clk);
    @(negedge clk);
    start  = 1'b1;
    header = hdr;
    @(negedge clk);
    start  = 1'b0;
    header = ~hdr;
    first_ready = -1;
    done_at     = -1;
    under_at    = -1;
    n_ready     = 0;
    n_done      = 0;
    for (int i = 0; i < exp_q.size() + 4; i++) begin
      exp_t e;
      logic eb;
      if (i < exp_q.size()) begin
        e  = exp_q[i];
        eb = 1'b1;
      end else begin
        e  = '0;
        eb = 1'b0;
      end
      check($sformatf("%s aud@%0d", tag, i),      32'(aud),            32'(e.aud));
      check($sformatf("%s busy@%0d", tag, i),     32'(busy),           32'(eb));
      check($sformatf("%s ready@%0d", tag, i),    32'(bif.byte_ready), 32'(e.ready));
      check($sformatf("%s done@%0d", tag, i),     32'(done),           32'(e.done));
      check($sformatf("%s underrun@%0d", tag, i), 32'(underrun),       32'(e.under));
      if (bif.byte_ready === 1'b1) begin
        n_ready++;
        if (first_ready < 0) first_ready = i;
      end
      if (done === 1'b1) begin
        n_done++;
        done_at = i;
      end
      if (underrun === 1'b1) under_at = i;
      if (i == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check({tag, " aud after reset"},      32'(aud),            32'd0);
        check({tag, " busy after reset"},     32'(busy),           32'd0);
        check({tag, " ready after reset"},    32'(bif.byte_ready), 32'd0);
        check({tag, " done after reset"},     32'(done),           32'd0);
        check({tag, " underrun after reset"}, 32'(underrun),       32'd0);
        byte_q.delete();
        return;
      end
      if (i == spur_a || i == spur_b) begin
        start  = 1'b1;
        header = ~header;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  // --------------------------------------------------------------- sequence
  initial begin
    repeat (3) @(negedge clk);
    check("reset aud",      32'(aud),            32'd0);
    check("reset busy",     32'(busy),           32'd0);
    check("reset ready",    32'(bif.byte_ready), 32'd0);
    check("reset done",     32'(done),           32'd0);
    check("reset underrun", 32'(underrun),       32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle busy", 32'(busy), 32'd0);

    // Header block: 5 pilots, syncs, LOAD at 5*21+6+7 = 118.
    stim_data = '{8'h3C};
    stim_last = '{1'b1};
    run_block("hdr", 1'b1, -1, -1, -1);
    check("hdr first ready", 32'(first_ready), 32'd118);
    check("hdr done count",  32'(n_done),      32'd1);

    // 0xA5: 63+13 = 76 lead-in, 200 data + 1 stretch, 35 pause -> done at 311.
    stim_data = '{8'hA5};
    stim_last = '{1'b1};
    run_block("a5", 1'b0, -1, -1, -1);
    check("a5 model length", 32'(exp_q.size()), 32'd312);
    check("a5 done cycle",   32'(done_at),      32'd311);
    check("a5 ready count",  32'(n_ready),      32'd1);

    // 0x00 then 0xFF: 76 + 130 + 272 = 478, done at 512.
    stim_data = '{8'h00, 8'hFF};
    stim_last = '{1'b0, 1'b1};
    run_block("multi", 1'b0, -1, -1, -1);
    check("multi ready count", 32'(n_ready), 32'd2);
    check("multi done count",  32'(n_done),  32'd1);
    check("multi done cycle",  32'(done_at), 32'd512);

    // Zero-byte block: LOAD at 76, underrun at 77, done at 111.
    stim_data.delete();
    stim_last.delete();
    run_block("under0", 1'b0, -1, -1, -1);
    check("under0 underrun cycle", 32'(under_at), 32'd77);
    check("under0 done cycle",     32'(done_at),  32'd111);
    check("under0 done count",     32'(n_done),   32'd1);

    // Truncated after one non-final byte 0x55: LOAD at 277, underrun at 278.
    stim_data = '{8'h55};
    stim_last = '{1'b0};
    run_block("trunc", 1'b0, -1, -1, -1);
    check("trunc underrun cycle", 32'(under_at), 32'd278);
    check("trunc done cycle",     32'(done_at),  32'd312);

    // Spurious start in PILOT (cycle 40) and PAUSE (cycle 300); 0x81 header
    // block: 118 + 165 active, done at 317.
    stim_data = '{8'h81};
    stim_last = '{1'b1};
    run_block("spur", 1'b1, 40, 300, -1);
    check("spur done cycle", 32'(done_at), 32'd317);
    check("spur done count", 32'(n_done),  32'd1);

    // Reset in the middle of DATA, then a normal block.
    stim_data = '{8'hF0};
    stim_last = '{1'b1};
    run_block("abort", 1'b0, -1, -1, 150);
    stim_data = '{8'h3C};
    stim_last = '{1'b1};
    run_block("after", 1'b0, -1, -1, -1);
    check("after done cycle", 32'(done_at), 32'd311);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
